// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the audio-sample memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RD,
      DONE
   } arb_state_t;

   localparam int unsigned REQ_REC   = 0;
   localparam int unsigned REQ_PLAY  = 1;
   localparam int unsigned REQ_MIX   = 2;
   localparam int unsigned REQ_PITCH = 3;

   localparam int unsigned DEF_N_REQ  = 4;
   localparam int unsigned DEF_ADDR_W = 23;
   localparam int unsigned DEF_DATA_W = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Engine-side handshake plus memory-controller bus of the port arbiter.
interface mem_port_arbiter_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ADDR_W = 23,
   parameter int unsigned DATA_W = 16
);

   logic [N_REQ-1:0]        i_req;
   logic [N_REQ-1:0]        i_we;
   logic [N_REQ*ADDR_W-1:0] i_addr;
   logic [N_REQ*DATA_W-1:0] i_wdata;
   logic [N_REQ-1:0]        o_ack;
   logic [DATA_W-1:0]       o_rdata;
   logic                    o_err;
   logic                    o_busy;
   logic [ADDR_W-1:0]       o_mem_addr;
   logic [DATA_W-1:0]       o_mem_wdata;
   logic                    o_mem_read;
   logic                    o_mem_write;
   logic                    i_mem_waitrequest;
   logic [DATA_W-1:0]       i_mem_rdata;
   logic                    i_mem_readdatavalid;

   modport slave (
      input  i_req, i_we, i_addr, i_wdata,
      input  i_mem_waitrequest, i_mem_rdata, i_mem_readdatavalid,
      output o_ack, o_rdata, o_err, o_busy,
      output o_mem_addr, o_mem_wdata, o_mem_read, o_mem_write
   );

   modport master (
      output i_req, i_we, i_addr, i_wdata,
      output i_mem_waitrequest, i_mem_rdata, i_mem_readdatavalid,
      input  o_ack, o_rdata, o_err, o_busy,
      input  o_mem_addr, o_mem_wdata, o_mem_read, o_mem_write
   );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after the last grant.
module rr_pick #(
   parameter int unsigned N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] last,
   output logic [$clog2(N_REQ)-1:0] win,
   output logic                     valid
);

   localparam int unsigned IW = $clog2(N_REQ);

   always_comb begin
      int unsigned idx;
      idx   = 0;
      win   = '0;
      valid = 1'b0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = (32'(last) + k) % N_REQ;
         if (!valid && req[idx[IW-1:0]]) begin
            win   = idx[IW-1:0];
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port arbiter for the record/play/mix/pitch engines.
// MEM_ARB_REC_PRIO_EN: record requester gets strict priority over the rotation.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned N_REQ      = DEF_N_REQ,
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned RD_TIMEOUT = 255
) (
   input  logic               i_clk,
   input  logic               i_rst,
   mem_port_arbiter_if.slave  bus
);

   localparam int unsigned IW = $clog2(N_REQ);
   localparam int unsigned CW = $clog2(RD_TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(RD_TIMEOUT - 1);

   arb_state_t       state;
   logic [IW-1:0]    grant;
   logic [IW-1:0]    last_grant;
   logic [CW-1:0]    to_cnt;
   logic             we_q;
   logic [N_REQ-1:0] rr_req;
   logic [IW-1:0]    pick_idx;
   logic             pick_valid;
   logic [IW-1:0]    win;
   logic             win_valid;
   logic             upd_last;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req   (rr_req),
      .last  (last_grant),
      .win   (pick_idx),
      .valid (pick_valid)
   );

`ifdef MEM_ARB_REC_PRIO_EN
   // Record is masked out of the rotation so its grants never move last_grant.
   assign rr_req = {bus.i_req[N_REQ-1:1], 1'b0};

   always_comb begin
      win       = pick_idx;
      win_valid = pick_valid;
      upd_last  = 1'b1;
      if (bus.i_req[REQ_REC]) begin
         win       = IW'(REQ_REC);
         win_valid = 1'b1;
         upd_last  = 1'b0;
      end
   end
`else
   assign rr_req    = bus.i_req;
   assign win       = pick_idx;
   assign win_valid = pick_valid;
   assign upd_last  = 1'b1;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state           <= IDLE;
         grant           <= '0;
         last_grant      <= IW'(N_REQ - 1);
         to_cnt          <= '0;
         we_q            <= 1'b0;
         bus.o_ack       <= '0;
         bus.o_rdata     <= '0;
         bus.o_err       <= 1'b0;
         bus.o_busy      <= 1'b0;
         bus.o_mem_addr  <= '0;
         bus.o_mem_wdata <= '0;
         bus.o_mem_read  <= 1'b0;
         bus.o_mem_write <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_valid) begin
                  grant <= win;
                  if (upd_last) last_grant <= win;
                  we_q            <= bus.i_we[win];
                  bus.o_mem_addr  <= bus.i_addr[win*ADDR_W +: ADDR_W];
                  bus.o_mem_wdata <= bus.i_wdata[win*DATA_W +: DATA_W];
                  bus.o_mem_write <= bus.i_we[win];
                  bus.o_mem_read  <= ~bus.i_we[win];
                  bus.o_busy      <= 1'b1;
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               if (!bus.i_mem_waitrequest) begin
                  bus.o_mem_read  <= 1'b0;
                  bus.o_mem_write <= 1'b0;
                  if (we_q) begin
                     bus.o_ack <= N_REQ'(1) << grant;
                     bus.o_err <= 1'b0;
                     state     <= DONE;
                  end else begin
                     to_cnt <= '0;
                     state  <= WAIT_RD;
                  end
               end
            end
            WAIT_RD: begin
               if (bus.i_mem_readdatavalid) begin
                  bus.o_rdata <= bus.i_mem_rdata;
                  bus.o_err   <= 1'b0;
                  bus.o_ack   <= N_REQ'(1) << grant;
                  state       <= DONE;
               end else if (to_cnt == TO_LAST) begin
                  bus.o_rdata <= '0;
                  bus.o_err   <= 1'b1;
                  bus.o_ack   <= N_REQ'(1) << grant;
                  state       <= DONE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            DONE: begin
               bus.o_ack  <= '0;
               bus.o_busy <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a scoreboard and a stalling memory model.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int unsigned NR = 4;
   localparam int unsigned AW = 23;
   localparam int unsigned DW = 16;

   typedef struct {
      int unsigned   idx;
      logic [DW-1:0] rdata;
      logic          err;
      bit            is_rd;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sbq[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned n_acks = 0;

   // memory model state
   int unsigned   cfg_stall = 0;
   int unsigned   cfg_lat = 1;
   bit            cfg_noresp = 0;
   bit            stray_rdv = 0;
   bit            in_cmd = 0;
   bit            acc_pend = 0;
   bit            acc_we = 0;
   int unsigned   stall_left = 0;
   int unsigned   rd_pend = 0;
   logic [AW-1:0] acc_addr;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] acc_wdata;
   logic [DW-1:0] mem_arr [logic [AW-1:0]];

   mem_port_arbiter_if #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(
      .N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(4)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      forever begin
         @(negedge clk);
         if (|bus.o_ack) n_acks++;
      end
   end

   // Memory controller: stalls a new command cfg_stall cycles, answers reads cfg_lat cycles after acceptance.
   initial begin
      bus.i_mem_waitrequest   = 1'b0;
      bus.i_mem_readdatavalid = 1'b0;
      bus.i_mem_rdata         = '0;
      forever begin
         @(posedge clk); #1;
         bus.i_mem_readdatavalid = 1'b0;
         if (rst) begin
            in_cmd = 0; acc_pend = 0; rd_pend = 0;
            bus.i_mem_waitrequest = 1'b0;
            continue;
         end
         if (stray_rdv) begin
            bus.i_mem_readdatavalid = 1'b1;
            bus.i_mem_rdata = 16'hDEAD;
            stray_rdv = 0;
         end
         if (acc_pend) begin
            acc_pend = 0;
            if (acc_we) mem_arr[acc_addr] = acc_wdata;
            else if (!cfg_noresp) begin
               rd_pend = cfg_lat;
               rd_addr = acc_addr;
            end
         end
         if (rd_pend > 0) begin
            rd_pend--;
            if (rd_pend == 0) begin
               bus.i_mem_readdatavalid = 1'b1;
               bus.i_mem_rdata = mem_arr.exists(rd_addr) ? mem_arr[rd_addr] : ~rd_addr[DW-1:0];
            end
         end
         if (bus.o_mem_read || bus.o_mem_write) begin
            if (!in_cmd) begin
               in_cmd = 1;
               stall_left = cfg_stall;
            end
            if (stall_left > 0) begin
               bus.i_mem_waitrequest = 1'b1;
               stall_left--;
            end else begin
               bus.i_mem_waitrequest = 1'b0;
               in_cmd    = 0;
               acc_pend  = 1;
               acc_we    = bus.o_mem_write;
               acc_addr  = bus.o_mem_addr;
               acc_wdata = bus.o_mem_wdata;
            end
         end else begin
            bus.i_mem_waitrequest = 1'b0;
         end
      end
   end

   task automatic set_req(input int unsigned i, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      bus.i_req[i] = 1'b1;
      bus.i_we[i]  = we;
      bus.i_addr[i*AW +: AW]  = a;
      bus.i_wdata[i*DW +: DW] = d;
   endtask

   task automatic clr_all();
      bus.i_req = '0;
      bus.i_we  = '0;
   endtask

   task automatic wait_ack(output bit got, output int unsigned lat);
      got = 0;
      lat = 0;
      for (int unsigned c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         if (|bus.o_ack) begin
            got = 1;
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.o_ack !== 4'b0 || bus.o_busy !== 1'b0 || bus.o_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: ack=%b busy=%b err=%b, need 0000/0/0", bus.o_ack, bus.o_busy, bus.o_err);
      end
      n_cmp++;
      if (bus.o_mem_read !== 1'b0 || bus.o_mem_write !== 1'b0 || bus.o_rdata !== 16'h0 ||
          bus.o_mem_addr !== 23'h0) begin
         n_bad++;
         $display("FAIL reset_mem: rd=%b wr=%b rdata=%h addr=%h, need all 0", bus.o_mem_read,
                  bus.o_mem_write, bus.o_rdata, bus.o_mem_addr);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_fairness();
      bit got;
      int unsigned lat;
      exp_t e;
      logic [NR-1:0] exp_ack;
      for (int unsigned i = 0; i < NR; i++) set_req(i, 1'b1, 23'h200 + AW'(i), 16'h1000 + DW'(i));
      for (int unsigned k = 0; k < 5; k++) begin
`ifdef MEM_ARB_REC_PRIO_EN
         sbq.push_back('{idx: REQ_REC, rdata: '0, err: 1'b0, is_rd: 1'b0});
`else
         sbq.push_back('{idx: k % NR, rdata: '0, err: 1'b0, is_rd: 1'b0});
`endif
      end
      for (int unsigned k = 0; k < 5; k++) begin
         wait_ack(got, lat);
         n_cmp++;
         if (!got) begin
            n_bad++;
            $display("FAIL fair_timeout: grant %0d got no ack within 60 cycles", k);
            break;
         end
         e = sbq.pop_front();
         exp_ack = 4'b0001 << e.idx;
         n_cmp++;
         if (bus.o_ack !== exp_ack) begin
            n_bad++;
            $display("FAIL fair_order: grant %0d ack=%b, need %b", k, bus.o_ack, exp_ack);
         end
         n_cmp++;
         if (lat !== ((k == 0) ? 2 : 3)) begin
            n_bad++;
            $display("FAIL fair_spacing: grant %0d latency=%0d, need %0d", k, lat, (k == 0) ? 2 : 3);
         end
      end
      clr_all();
      sbq.delete();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_single_write();
      bit got;
      int unsigned lat;
      exp_t e;
      set_req(REQ_PLAY, 1'b1, 23'h000100, 16'hBEEF);
      sbq.push_back('{idx: REQ_PLAY, rdata: '0, err: 1'b0, is_rd: 1'b0});
      @(posedge clk); #1;
      n_cmp++;
      if (bus.o_mem_write !== 1'b1 || bus.o_mem_read !== 1'b0 || bus.o_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL wr_strobe: wr=%b rd=%b busy=%b at cycle 1, need 1/0/1", bus.o_mem_write,
                  bus.o_mem_read, bus.o_busy);
      end
      n_cmp++;
      if (bus.o_mem_addr !== 23'h000100 || bus.o_mem_wdata !== 16'hBEEF) begin
         n_bad++;
         $display("FAIL wr_bus: addr=%h wdata=%h, need 000100/beef", bus.o_mem_addr, bus.o_mem_wdata);
      end
      wait_ack(got, lat);
      e = sbq.pop_front();
      n_cmp++;
      if (!got || lat !== 1 || bus.o_ack !== (4'b0001 << e.idx) || bus.o_err !== e.err) begin
         n_bad++;
         $display("FAIL wr_ack: got=%0d extra_lat=%0d ack=%b err=%b, need 1/1/%b/%b", got, lat,
                  bus.o_ack, bus.o_err, 4'b0001 << e.idx, e.err);
      end
      clr_all();
      @(posedge clk); #1;
      n_cmp++;
      if (bus.o_ack !== 4'b0 || bus.o_mem_write !== 1'b0) begin
         n_bad++;
         $display("FAIL wr_pulse: ack=%b wr=%b one cycle after ack, need 0000/0", bus.o_ack,
                  bus.o_mem_write);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_read_stall();
      bit got;
      int unsigned lat;
      exp_t e;
      mem_arr[23'h7FFFFF] = 16'h1234;
      cfg_stall = 3;
      cfg_lat   = 2;
      set_req(REQ_MIX, 1'b0, 23'h7FFFFF, 16'h0);
      sbq.push_back('{idx: REQ_MIX, rdata: 16'h1234, err: 1'b0, is_rd: 1'b1});
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.o_mem_read !== 1'b1 || bus.o_mem_addr !== 23'h7FFFFF) begin
         n_bad++;
         $display("FAIL rd_hold: rd=%b addr=%h while stalled, need 1/7fffff", bus.o_mem_read,
                  bus.o_mem_addr);
      end
      wait_ack(got, lat);
      e = sbq.pop_front();
      n_cmp++;
      if (!got || lat !== 5 || bus.o_ack !== (4'b0001 << e.idx)) begin
         n_bad++;
         $display("FAIL rd_stall_ack: got=%0d rest_lat=%0d ack=%b, need 1/5/%b", got, lat,
                  bus.o_ack, 4'b0001 << e.idx);
      end
      n_cmp++;
      if (bus.o_rdata !== e.rdata || bus.o_err !== e.err) begin
         n_bad++;
         $display("FAIL rd_stall_data: rdata=%h err=%b, need %h/%b", bus.o_rdata, bus.o_err,
                  e.rdata, e.err);
      end
      clr_all();
      repeat (2) @(posedge clk);
      #1;
      // zero-stall read-back of the earlier write
      cfg_stall = 0;
      cfg_lat   = 1;
      set_req(REQ_PITCH, 1'b0, 23'h000100, 16'h0);
      sbq.push_back('{idx: REQ_PITCH, rdata: 16'hBEEF, err: 1'b0, is_rd: 1'b1});
      wait_ack(got, lat);
      e = sbq.pop_front();
      n_cmp++;
      if (!got || lat !== 3 || bus.o_ack !== (4'b0001 << e.idx) || bus.o_rdata !== e.rdata) begin
         n_bad++;
         $display("FAIL rd_fast: got=%0d lat=%0d ack=%b rdata=%h, need 1/3/%b/%h", got, lat,
                  bus.o_ack, bus.o_rdata, 4'b0001 << e.idx, e.rdata);
      end
      clr_all();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_timeout();
      bit got;
      int unsigned lat;
      int unsigned acks_before;
      exp_t e;
      cfg_noresp = 1;
      set_req(REQ_REC, 1'b0, 23'h000055, 16'h0);
      sbq.push_back('{idx: REQ_REC, rdata: 16'h0, err: 1'b1, is_rd: 1'b1});
      wait_ack(got, lat);
      e = sbq.pop_front();
      n_cmp++;
      if (!got || lat !== 6 || bus.o_ack !== (4'b0001 << e.idx)) begin
         n_bad++;
         $display("FAIL to_ack: got=%0d lat=%0d ack=%b, need 1/6/%b", got, lat, bus.o_ack,
                  4'b0001 << e.idx);
      end
      n_cmp++;
      if (bus.o_err !== e.err || bus.o_rdata !== e.rdata) begin
         n_bad++;
         $display("FAIL to_flag: err=%b rdata=%h, need %b/%h", bus.o_err, bus.o_rdata, e.err, e.rdata);
      end
      clr_all();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.o_err !== 1'b1 || bus.o_rdata !== 16'h0) begin
         n_bad++;
         $display("FAIL to_stable: err=%b rdata=%h after ack, need 1/0000", bus.o_err, bus.o_rdata);
      end
      acks_before = n_acks;
      stray_rdv = 1;
      repeat (6) @(posedge clk);
      #1;
      n_cmp++;
      if (n_acks !== acks_before || bus.o_busy !== 1'b0 || bus.o_rdata !== 16'h0) begin
         n_bad++;
         $display("FAIL stray_rdv: acks=%0d busy=%b rdata=%h, need %0d/0/0000", n_acks,
                  bus.o_busy, bus.o_rdata, acks_before);
      end
      cfg_noresp = 0;
   endtask

   task automatic test_reset_mid();
      bit got;
      int unsigned lat;
      exp_t e;
      cfg_stall  = 5;
      set_req(REQ_PLAY, 1'b0, 23'h000321, 16'h0);
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.o_mem_read !== 1'b0 || bus.o_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_issue: rd=%b busy=%b right after reset, need 0/0", bus.o_mem_read,
                  bus.o_busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      clr_all();
      cfg_stall  = 0;
      cfg_noresp = 1;
      @(posedge clk); #1;
      set_req(REQ_MIX, 1'b0, 23'h000400, 16'h0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.o_mem_read !== 1'b0 || bus.o_ack !== 4'b0 || bus.o_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_wait_rd: rd=%b ack=%b busy=%b right after reset, need 0/0000/0",
                  bus.o_mem_read, bus.o_ack, bus.o_busy);
      end
      clr_all();
      cfg_noresp = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      set_req(REQ_PITCH, 1'b1, 23'h000777, 16'h5A5A);
      sbq.push_back('{idx: REQ_PITCH, rdata: '0, err: 1'b0, is_rd: 1'b0});
      wait_ack(got, lat);
      e = sbq.pop_front();
      n_cmp++;
      if (!got || lat !== 2 || bus.o_ack !== (4'b0001 << e.idx)) begin
         n_bad++;
         $display("FAIL rst_regrant: got=%0d lat=%0d ack=%b, need 1/2/%b", got, lat, bus.o_ack,
                  4'b0001 << e.idx);
      end
      clr_all();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.i_req   = '0;
      bus.i_we    = '0;
      bus.i_addr  = '0;
      bus.i_wdata = '0;
      test_reset();
      test_fairness();
      test_single_write();
      test_read_stall();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
